// File: rtl/clock_time_controller.sv
// clock_time_controller: 12-hour timekeeping, alarm time, alarm arm/ring/silence FSM and buzzer drive.
`default_nettype none

module clock_time_controller #(
  parameter int RING_SECONDS = 60,
  parameter int AL_STEP_MIN  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_buzz,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       ringing,
  output logic       buzzer
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);
  localparam logic [6:0] AL_STEP   = 7'(AL_STEP_MIN);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic       tick_pend, tick_pend_next;
  logic       match_d, match, match_rise;
  logic [7:0] ring_cnt, ring_cnt_next;
  logic       buzzer_next;
  logic       any_adj, do_tick, timeout;
  logic [5:0] sec_next, min_next, al_min_next;
  logic [3:0] hrs_next, al_hrs_next;
  logic [6:0] al_sum, al_wrap;

  // A tick that collides with a time adjust is deferred by one cycle via tick_pend.
  assign any_adj        = sec_adj | min_adj | hrs_adj;
  assign do_tick        = !any_adj && (tick_1hz || tick_pend);
  assign tick_pend_next = any_adj && (tick_pend || tick_1hz);

  always_comb begin
    sec_next = seconds;
    min_next = minutes;
    hrs_next = hours;
    if (do_tick) begin
      if (seconds == 6'd59) begin
        sec_next = 6'd0;
        if (minutes == 6'd59) begin
          min_next = 6'd0;
          hrs_next = (hours == 4'd11) ? 4'd0 : hours + 4'd1;
        end else begin
          min_next = minutes + 6'd1;
        end
      end else begin
        sec_next = seconds + 6'd1;
      end
    end else begin
      if (sec_adj) sec_next = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
      if (min_adj) min_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      if (hrs_adj) hrs_next = (hours == 4'd11) ? 4'd0 : hours + 4'd1;
    end
  end

  assign al_sum  = {1'b0, al_minutes} + AL_STEP;
  assign al_wrap = al_sum - 7'd60;

  always_comb begin
    al_min_next = al_minutes;
    al_hrs_next = al_hours;
    if (al_adj) begin
      if (al_sum >= 7'd60) begin
        al_min_next = al_wrap[5:0];
        al_hrs_next = (al_hours == 4'd11) ? 4'd0 : al_hours + 4'd1;
      end else begin
        al_min_next = al_sum[5:0];
      end
    end
  end

  assign match      = (hours == al_hours) && (minutes == al_minutes) && (seconds == 6'd0);
  assign match_rise = match && !match_d;
  assign timeout    = tick_1hz && (ring_cnt == RING_LAST);

  always_comb begin
    state_next    = state;
    ring_cnt_next = ring_cnt;
    case (state)
      DISARMED: begin
        if (al_toggle) state_next = ARMED;
      end
      ARMED: begin
        if (al_toggle) begin
          state_next = DISARMED;
        end else if (match_rise) begin
          state_next    = RINGING;
          ring_cnt_next = 8'd0;
        end
      end
      RINGING: begin
        if (al_toggle || timeout) begin
          state_next = ARMED;
        end else if (tick_1hz) begin
          ring_cnt_next = ring_cnt + 8'd1;
        end
      end
      default: state_next = ARMED;
    endcase
  end

  // Buzzer only runs while staying in RINGING; entry and exit both force it low.
  assign buzzer_next = (state == RINGING && state_next == RINGING) ? (buzzer ^ tick_buzz) : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      seconds    <= 6'd0;
      minutes    <= 6'd0;
      hours      <= 4'd0;
      al_minutes <= 6'd0;
      al_hours   <= 4'd0;
      state      <= ARMED;
      tick_pend  <= 1'b0;
      ring_cnt   <= 8'd0;
      match_d    <= 1'b1;
      buzzer     <= 1'b0;
      al_on      <= 1'b1;
      ringing    <= 1'b0;
    end else begin
      seconds    <= sec_next;
      minutes    <= min_next;
      hours      <= hrs_next;
      al_minutes <= al_min_next;
      al_hours   <= al_hrs_next;
      state      <= state_next;
      tick_pend  <= tick_pend_next;
      ring_cnt   <= ring_cnt_next;
      match_d    <= match;
      buzzer     <= buzzer_next;
      al_on      <= (state_next != DISARMED);
      ringing    <= (state_next == RINGING);
    end
  end

endmodule

`default_nettype wire

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
- Sequences the timekeeping and alarm registers that feed the VGA clock-face renderer and the bell symbol.
- Advances seconds, minutes and hours (12-hour) on a 1 Hz tick pulse.
- Applies debounced adjust-button pulses and runs the alarm arm/ring/silence state machine.
- Drives the buzzer square wave from a buzzer-rate tick.
- Sits between the clock dividers / button debouncers and the renderer / buzzer pin.

Parameters:
- RING_SECONDS, 60, number of 1 Hz ticks RINGING lasts before auto-silence; range 1..255.
- AL_STEP_MIN, 10, minutes added to the alarm time per al_adj pulse; range 1..59.

Ports:
- clk  in  1  system clock (31.5 MHz)
- reset  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse, once per second
- tick_buzz  in  1  one-cycle pulse at twice the buzzer tone frequency
- sec_adj  in  1  one-cycle debounced pulse: seconds +1
- min_adj  in  1  one-cycle debounced pulse: minutes +1
- hrs_adj  in  1  one-cycle debounced pulse: hours +1
- al_adj  in  1  one-cycle debounced pulse: alarm time +AL_STEP_MIN minutes
- al_toggle  in  1  one-cycle debounced pulse: arm / disarm / silence
- seconds  out  6  0..59
- minutes  out  6  0..59
- hours  out  4  0..11
- al_minutes  out  6  0..59
- al_hours  out  4  0..11
- al_on  out  1  high in ARMED or RINGING; drives the bell symbol
- ringing  out  1  high in RINGING
- buzzer  out  1  square wave while ringing, else 0

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values:
  - seconds, minutes, hours, al_minutes, al_hours = 0.
  - State = ARMED, so al_on=1, ringing=0, buzzer=0.
  - tick_pend=0, ring_cnt=0, match_d=1. match_d=1 prevents ringing at the 00:00 = 00:00 reset condition.
- All outputs are registered. An input pulse at cycle N is visible on the outputs at N+1.
- Tick path (carry chain), applied when a tick occurs at cycle N, or when tick_pend is consumed:
  - seconds 59->0 carries to minutes.
  - minutes 59->0 carries to hours.
  - hours 11->0.
  - Full wrap is 11:59:59 -> 00:00:00.
- Adjust path (no carry):
  - sec_adj: seconds 59->0 only.
  - min_adj: minutes 59->0 only.
  - hrs_adj: hours 11->0.
  - Each adjust touches its own field only.
- Simultaneous adjust pulses on different fields in one cycle: all are applied.
- Collision: tick_1hz arriving in the same cycle as any of sec_adj, min_adj or hrs_adj:
  - The adjust(s) are applied and the tick sets tick_pend.
  - tick_pend is consumed on the next cycle with no time adjust: the tick path is applied and tick_pend is cleared.
  - A second tick while tick_pend=1 is impossible in practice (1 Hz). If it occurs, tick_pend stays 1; at most one tick is deferred.
- Alarm adjust, on al_adj:
  - al_minutes += AL_STEP_MIN. On reaching 60 or more, subtract 60 and increment al_hours.
  - al_hours wraps 11->0.
  - Internal arithmetic is 7 bits wide.
- Match detection:
  - match = (hours==al_hours) && (minutes==al_minutes) && (seconds==0), evaluated on registered values.
  - match_d <= match every cycle.
  - match_rise = match && !match_d.
- State machine, states DISARMED, ARMED, RINGING:
  - DISARMED: al_toggle -> ARMED. match is ignored.
  - ARMED:
    - al_toggle -> DISARMED.
    - match_rise -> RINGING, ring_cnt <= 0.
    - If al_toggle and match_rise occur in the same cycle, al_toggle wins -> DISARMED.
  - RINGING:
    - al_toggle -> ARMED (silence, stays armed).
    - Each tick_1hz increments ring_cnt. When ring_cnt == RING_SECONDS-1 and tick_1hz occurs -> ARMED.
    - If al_toggle and the timeout occur in the same cycle, the result is ARMED.
  - Returning to ARMED while match is still true does not retrigger, because match_d=1.
- Buzzer:
  - In RINGING, buzzer toggles on each tick_buzz.
  - Leaving RINGING forces buzzer=0 in the same transition cycle.
  - Entering RINGING starts buzzer at 0.
- Alarm-time adjustments and time adjustments are legal in every state.
  - Adjusting the time onto the alarm value while ARMED triggers ringing via match_rise.
- Reset asserted mid-ring immediately returns to the full reset state in the next cycle.

Test Plan:
- Reset checks:
  - Hold reset 3 cycles, release -> all time registers 0, al_on=1, ringing=0, buzzer=0.
  - Run 2 ticks -> no ring.
- Rollover:
  - Preload 11:59:59 via adjust pulses (11 hrs_adj, 59 min_adj, 59 sec_adj) in DISARMED, then one tick_1hz -> 00:00:00 next cycle.
  - A sec_adj at seconds=59 -> seconds=0 and minutes unchanged.
- Collision:
  - tick_1hz and min_adj in the same cycle at 00:05:30 -> 00:06:30 at N+1, 00:06:31 at N+2.
- Alarm adjust wrap:
  - 6 al_adj pulses from 00:00 -> al_hours=1, al_minutes=0.
  - 72 al_adj pulses from reset -> wraps back to 0:00.
- Ring and timeout:
  - Alarm 01:00, time advanced by ticks to 01:00:00 while ARMED -> ringing=1 the cycle after match.
  - buzzer toggles per tick_buzz.
  - After 60 ticks -> ringing=0, al_on=1, buzzer=0, no retrigger.
- Silence and disarm:
  - al_toggle during RINGING -> ARMED.
  - al_toggle again -> al_on=0.
  - Set the time onto the alarm again while DISARMED -> ringing stays 0.
  - al_toggle coincident with match_rise in ARMED -> DISARMED.
